// File: rtl/led_display_frame_scanner_pkg.sv
// Shared constants, row/pixel types and FSM states for the LED frame scanner.
package led_display_package;

  localparam int unsigned NUM_ROW_PIXELS = 32;
  localparam int unsigned NUM_COL_PIXELS = 64;
  localparam int unsigned COLOUR_DEPTH   = 4;

  localparam int unsigned NUM_SCAN_ROWS  = NUM_ROW_PIXELS / 2;
  localparam int unsigned PIXEL_WIDTH    = 3 * COLOUR_DEPTH;
  localparam int unsigned ROW_ADDR_WIDTH = $clog2(NUM_SCAN_ROWS);
  localparam int unsigned COL_ADDR_WIDTH = $clog2(NUM_COL_PIXELS);
  localparam int unsigned MEM_ADDR_WIDTH = 1 + ROW_ADDR_WIDTH + COL_ADDR_WIDTH;
  localparam int unsigned PLANE_WIDTH    = $clog2(COLOUR_DEPTH);

  // One read per column per half; one spare bit so the counter can reach the drain cycle.
  localparam int unsigned FETCH_COUNT    = 2 * NUM_COL_PIXELS;
  localparam int unsigned FETCH_WIDTH    = $clog2(FETCH_COUNT) + 1;

  localparam int unsigned RED_OFFSET     = 0;
  localparam int unsigned GREEN_OFFSET   = COLOUR_DEPTH;
  localparam int unsigned BLUE_OFFSET    = 2 * COLOUR_DEPTH;

  typedef struct packed {
    logic [NUM_COL_PIXELS-1:0] red_top;
    logic [NUM_COL_PIXELS-1:0] green_top;
    logic [NUM_COL_PIXELS-1:0] blue_top;
    logic [NUM_COL_PIXELS-1:0] red_bot;
    logic [NUM_COL_PIXELS-1:0] green_bot;
    logic [NUM_COL_PIXELS-1:0] blue_bot;
  } rgb_row_t;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StPresent
  } scanner_state_t;

  // Last repeat index of a bit-plane: plane p is shown 2^p times.
  function automatic logic [COLOUR_DEPTH-1:0] rep_limit(input logic [PLANE_WIDTH-1:0] plane);
    rep_limit = COLOUR_DEPTH'((32'd1 << plane) - 32'd1);
  endfunction

endpackage

// File: rtl/led_display_frame_scanner_if.sv
// Pixel-memory read port and row handshake between the scanner and its neighbours.
interface led_display_frame_scanner_if ();

  logic                                               mem_rd_en_out;
  logic [led_display_package::MEM_ADDR_WIDTH-1:0]     mem_addr_out;
  logic [led_display_package::PIXEL_WIDTH-1:0]        mem_data_in;
  led_display_package::rgb_row_t                      row_out;
  logic                                               row_valid_out;
  logic                                               row_ready_in;
  logic [led_display_package::ROW_ADDR_WIDTH-1:0]     row_address_out;
  logic                                               frame_start_out;
  logic                                               frame_done_out;

  modport master (
    output mem_rd_en_out,
    output mem_addr_out,
    input  mem_data_in,
    output row_out,
    output row_valid_out,
    input  row_ready_in,
    output row_address_out,
    output frame_start_out,
    output frame_done_out
  );

  modport slave (
    input  mem_rd_en_out,
    input  mem_addr_out,
    output mem_data_in,
    input  row_out,
    input  row_valid_out,
    output row_ready_in,
    input  row_address_out,
    input  frame_start_out,
    input  frame_done_out
  );

endinterface

// File: rtl/led_display_frame_scanner_plane_slicer.sv
// Picks one bit-plane out of a pixel word and writes it into the row register at one column.
module led_display_plane_slicer
  import led_display_package::*;
(
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      wr_en,
  input  logic                      half,
  input  logic [COL_ADDR_WIDTH-1:0] col,
  input  logic [PLANE_WIDTH-1:0]    plane,
  input  logic [PIXEL_WIDTH-1:0]    pixel,
  output rgb_row_t                  row
);

  logic [COLOUR_DEPTH-1:0] red_chan;
  logic [COLOUR_DEPTH-1:0] green_chan;
  logic [COLOUR_DEPTH-1:0] blue_chan;
  logic                    red_bit;
  logic                    green_bit;
  logic                    blue_bit;
  rgb_row_t                row_q;

  always_comb begin
    red_chan   = pixel[RED_OFFSET +: COLOUR_DEPTH];
    green_chan = pixel[GREEN_OFFSET +: COLOUR_DEPTH];
    blue_chan  = pixel[BLUE_OFFSET +: COLOUR_DEPTH];
    red_bit    = red_chan[plane];
    green_bit  = green_chan[plane];
    blue_bit   = blue_chan[plane];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      row_q <= '0;
    end else if (wr_en) begin
      if (half) begin
        row_q.red_bot[col]   <= red_bit;
        row_q.green_bot[col] <= green_bit;
        row_q.blue_bot[col]  <= blue_bit;
      end else begin
        row_q.red_top[col]   <= red_bit;
        row_q.green_top[col] <= green_bit;
        row_q.blue_top[col]  <= blue_bit;
      end
    end
  end

  assign row = row_q;

endmodule

// File: rtl/led_display_frame_scanner.sv
// Scans the framebuffer one bit-plane row at a time and presents BCM-repeated rows to the phy.
module led_display_frame_scanner
  import led_display_package::*;
(
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic                        enable_in,
  led_display_frame_scanner_if.master bus
);

  scanner_state_t            state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [PLANE_WIDTH-1:0]    plane_q, plane_d;
  logic [COLOUR_DEPTH-1:0]   rep_q, rep_d;
  logic [FETCH_WIDTH-1:0]    fetch_q, fetch_d;
  logic                      frame_start_q, frame_start_d;

  logic                      cap_en_q;
  logic                      cap_half_q;
  logic [COL_ADDR_WIDTH-1:0] cap_col_q;

  logic                      rd_en;
  logic                      row_valid;
  logic                      transfer;
  logic                      rep_last;
  logic                      plane_last;
  logic                      row_last;
  logic                      frame_done;
  rgb_row_t                  row_data;

  assign rd_en      = (state_q == StFetch) && !fetch_q[FETCH_WIDTH-1];
  assign row_valid  = (state_q == StPresent);
  assign transfer   = row_valid && bus.row_ready_in;
  assign rep_last   = (rep_q == rep_limit(plane_q));
  assign plane_last = (plane_q == PLANE_WIDTH'(COLOUR_DEPTH - 1));
  assign row_last   = (row_q == ROW_ADDR_WIDTH'(NUM_SCAN_ROWS - 1));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q       <= StIdle;
      row_q         <= '0;
      plane_q       <= '0;
      rep_q         <= '0;
      fetch_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      rep_q         <= rep_d;
      fetch_q       <= fetch_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    plane_d       = plane_q;
    rep_d         = rep_q;
    fetch_d       = fetch_q;
    frame_start_d = 1'b0;
    frame_done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable_in) begin
          state_d       = StFetch;
          row_d         = '0;
          plane_d       = '0;
          rep_d         = '0;
          fetch_d       = '0;
          frame_start_d = 1'b1;
        end
      end
      StFetch: begin
        fetch_d = fetch_q + 1'b1;
        // Last read was on the previous cycle; its data lands in the row register this cycle.
        if (fetch_q == FETCH_WIDTH'(FETCH_COUNT)) begin
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (transfer) begin
          if (!rep_last) begin
            rep_d = rep_q + 1'b1;
          end else begin
            rep_d   = '0;
            fetch_d = '0;
            state_d = StFetch;
            if (!plane_last) begin
              plane_d = plane_q + 1'b1;
            end else begin
              plane_d = '0;
              if (!row_last) begin
                row_d = row_q + 1'b1;
              end else begin
                row_d      = '0;
                frame_done = 1'b1;
                if (enable_in) begin
                  frame_start_d = 1'b1;
                end else begin
                  state_d = StIdle;
                end
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory data arrives one cycle after the strobe, so the write target trails by one cycle.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cap_en_q   <= 1'b0;
      cap_half_q <= 1'b0;
      cap_col_q  <= '0;
    end else begin
      cap_en_q   <= rd_en;
      cap_half_q <= fetch_q[0];
      cap_col_q  <= fetch_q[COL_ADDR_WIDTH:1];
    end
  end

  led_display_plane_slicer u_slicer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .wr_en    (cap_en_q),
    .half     (cap_half_q),
    .col      (cap_col_q),
    .plane    (plane_q),
    .pixel    (bus.mem_data_in),
    .row      (row_data)
  );

  assign bus.mem_rd_en_out   = rd_en;
  assign bus.mem_addr_out    = rd_en ? {fetch_q[0], row_q, fetch_q[COL_ADDR_WIDTH:1]} : '0;
  assign bus.row_out         = row_data;
  assign bus.row_valid_out   = row_valid;
  assign bus.row_address_out = row_q;
  assign bus.frame_start_out = frame_start_q;
  assign bus.frame_done_out  = frame_done;

endmodule
